// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch redirect sequencer: decodes the branch condition, latches the target,
// drives a one-cycle PC select and a multi-cycle pipeline flush, and keeps branch statistics.
module branch_redirect_ctrl #(
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch,
    input  logic [2:0]       funct,
    input  logic             zero,
    input  logic             is_greater,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             stall,
    output logic             pc_src,
    output logic [PC_W-1:0]  pc_target,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             busy,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        FLUSH
    } state_t;

    localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t     state, state_nxt;
    logic [2:0] flush_cnt, flush_cnt_nxt;
    logic       first, first_nxt;
    logic       taken;
    logic       count_branch, count_taken;

    always_comb begin
        case (funct)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b101:  taken = is_greater;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        first_nxt     = first;
        count_branch  = 1'b0;
        count_taken   = 1'b0;
        case (state)
            IDLE: begin
                if (branch) begin
                    count_branch = 1'b1;
                    if (taken) begin
                        count_taken = 1'b1;
                        if (stall) begin
                            state_nxt = PENDING;
                        end else begin
                            state_nxt     = FLUSH;
                            flush_cnt_nxt = FLUSH_LOAD;
                            first_nxt     = 1'b1;
                        end
                    end
                end
            end
            PENDING: begin
                if (!stall) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_LOAD;
                    first_nxt     = 1'b1;
                end
            end
            FLUSH: begin
                // A stalled cycle is not a flush cycle spent: counter and first-cycle flag hold.
                if (!stall) begin
                    first_nxt = 1'b0;
                    if (flush_cnt == 3'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        flush_cnt_nxt = flush_cnt - 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        pc_src      = (state == FLUSH) && first;
        flush_if_id = (state == FLUSH);
        flush_id_ex = (state == FLUSH);
        busy        = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            flush_cnt    <= '0;
            first        <= 1'b0;
            pc_target    <= '0;
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            first     <= first_nxt;
            if (count_branch && (branch_count != '1)) begin
                branch_count <= branch_count + CNT_ONE;
            end
            if (count_taken) begin
                pc_target <= branch_target;
                if (taken_count != '1) begin
                    taken_count <= taken_count + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: directed scenarios plus random traffic,
// checked against a redirect-bookkeeping model on a 16-bit-counter and a 4-bit-counter instance.
module tb_branch_redirect_ctrl;

    localparam int PC_W = 32;
    localparam int FC   = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            branch = 1'b0;
    logic [2:0]      funct = '0;
    logic            zero = 1'b0;
    logic            is_greater = 1'b0;
    logic [PC_W-1:0] branch_target = '0;
    logic            stall = 1'b0;

    logic            a_pc_src, a_fif, a_fex, a_busy;
    logic [PC_W-1:0] a_tgt;
    logic [15:0]     a_bc, a_tc;
    logic            b_pc_src, b_fif, b_fex, b_busy;
    logic [PC_W-1:0] b_tgt;
    logic [3:0]      b_bc, b_tc;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(FC), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .branch(branch), .funct(funct), .zero(zero),
        .is_greater(is_greater), .branch_target(branch_target), .stall(stall),
        .pc_src(a_pc_src), .pc_target(a_tgt), .flush_if_id(a_fif), .flush_id_ex(a_fex),
        .busy(a_busy), .branch_count(a_bc), .taken_count(a_tc)
    );

    branch_redirect_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(FC), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .branch(branch), .funct(funct), .zero(zero),
        .is_greater(is_greater), .branch_target(branch_target), .stall(stall),
        .pc_src(b_pc_src), .pc_target(b_tgt), .flush_if_id(b_fif), .flush_id_ex(b_fex),
        .busy(b_busy), .branch_count(b_bc), .taken_count(b_tc)
    );

    // Packed view: {pc_src, flush_if_id, flush_id_ex, busy, pc_target, branch_count, taken_count}
    typedef struct {
        logic [67:0] a;
        logic [67:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: a resolved redirect is either held (waiting for stall to drop) or
    // has some number of unstalled flush cycles left to spend.
    bit        m_held;
    int        m_flush_left;
    logic [31:0] m_tgt;
    int        m_bc, m_tc;

    function automatic bit cond_taken(input logic [2:0] f, input logic z, input logic g);
        if (f == 3'd0) return z;
        if (f == 3'd1) return !z;
        if (f == 3'd5) return g;
        return 1'b0;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic step(input logic rst, input logic br, input logic [2:0] f,
                        input logic z, input logic g, input logic [31:0] t, input logic st);
        exp_t        e;
        logic [3:0]  ctl;
        @(negedge clk);
        reset = rst; branch = br; funct = f; zero = z; is_greater = g;
        branch_target = t; stall = st;
        if (!rst) begin
            m_held = 0; m_flush_left = 0; m_tgt = '0; m_bc = 0; m_tc = 0;
        end else if (m_flush_left > 0) begin
            if (!st) m_flush_left--;
        end else if (m_held) begin
            if (!st) begin m_held = 0; m_flush_left = FC; end
        end else if (br) begin
            m_bc++;
            if (cond_taken(f, z, g)) begin
                m_tc++;
                m_tgt = t;
                if (st) m_held = 1; else m_flush_left = FC;
            end
        end
        ctl = {m_flush_left == FC, m_flush_left > 0, m_flush_left > 0, m_held || m_flush_left > 0};
        e.a = {ctl, m_tgt, 16'(sat(m_bc, 65535)), 16'(sat(m_tc, 65535))};
        e.b = {ctl, m_tgt, 12'd0, 4'(sat(m_bc, 15)), 12'd0, 4'(sat(m_tc, 15))};
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 3'd0, 0, 0, 32'h0, 0);
    endtask

    // Monitor: every rising edge the DUTs present a new output set.
    initial begin
        exp_t        e;
        logic [67:0] act_a, act_b;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                act_a = {a_pc_src, a_fif, a_fex, a_busy, a_tgt, a_bc, a_tc};
                act_b = {b_pc_src, b_fif, b_fex, b_busy, b_tgt, 12'd0, b_bc, 12'd0, b_tc};
                n_cmp++;
                if (act_a !== e.a) begin
                    n_bad++;
                    $display("FAIL dut16 t=%0t got ctl=%b tgt=%h bc=%0d tc=%0d want ctl=%b tgt=%h bc=%0d tc=%0d",
                             $time, act_a[67:64], act_a[63:32], act_a[31:16], act_a[15:0],
                             e.a[67:64], e.a[63:32], e.a[31:16], e.a[15:0]);
                end
                n_cmp++;
                if (act_b !== e.b) begin
                    n_bad++;
                    $display("FAIL dut4 t=%0t got ctl=%b tgt=%h bc=%0d tc=%0d want ctl=%b tgt=%h bc=%0d tc=%0d",
                             $time, act_b[67:64], act_b[63:32], act_b[31:16], act_b[15:0],
                             e.b[67:64], e.b[63:32], e.b[31:16], e.b[15:0]);
                end
            end
        end
    end

    initial begin
        logic [2:0] rf;
        m_held = 0; m_flush_left = 0; m_tgt = '0; m_bc = 0; m_tc = 0;

        step(0, 0, 3'd0, 0, 0, 32'h0, 0);
        step(0, 0, 3'd0, 0, 0, 32'h0, 0);
        // beq taken, plain flush
        step(1, 1, 3'd0, 1, 0, 32'h40, 0);
        idle(3);
        // three not-taken branches
        step(1, 1, 3'd1, 1, 0, 32'h100, 0);
        step(1, 1, 3'd5, 0, 0, 32'h104, 0);
        step(1, 1, 3'd2, 1, 0, 32'h108, 0);
        idle(2);
        // taken under stall, second branch ignored while pending
        step(1, 1, 3'd0, 1, 0, 32'h40, 1);
        step(1, 1, 3'd0, 1, 0, 32'h80, 1);
        step(1, 0, 3'd0, 0, 0, 32'h0, 1);
        idle(4);
        // stall in the second flush cycle, branch during flush not counted
        step(1, 1, 3'd5, 0, 1, 32'h200, 0);
        step(1, 1, 3'd0, 1, 0, 32'h300, 0);
        step(1, 0, 3'd0, 0, 0, 32'h0, 1);
        step(1, 0, 3'd0, 0, 0, 32'h0, 1);
        idle(3);
        // reset mid-FLUSH, then redirect right after release
        step(1, 1, 3'd0, 1, 0, 32'h400, 0);
        step(0, 0, 3'd0, 0, 0, 32'h0, 0);
        step(1, 1, 3'd1, 0, 0, 32'h440, 0);
        idle(3);
        // reset mid-PENDING
        step(1, 1, 3'd0, 1, 0, 32'h500, 1);
        step(0, 0, 3'd0, 0, 0, 32'h0, 1);
        step(1, 1, 3'd0, 1, 0, 32'h540, 0);
        idle(3);
        // saturation: 20 taken branches
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 3'd0, 1, 0, 32'h1000 + 32'(i * 4), 0);
            idle(2);
        end
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            rf = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 1) == 1), rf,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 9) < 3));
        end
        idle(3);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain leftover=%0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
